pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the parameter WAIT_MAX, default 8, meaning the maximum number of MEM_WAIT cycles before a memory error is declared (legal range 2..255).
REQ-002 The block SHALL have the parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, on the ports below.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  5  rs register number of the instruction in ID.
- id_rt  in  5  rt register number of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_MemtoReg  in  1  the EX instruction is a load.
- ex_RegWr  in  1  the EX instruction writes a register.
- ex_rw  in  5  destination register of the EX instruction.
- branch_taken  in  1  a branch or jump resolved taken in EX.
- mem_req  in  1  the MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  clear ID/EX (insert a bubble).
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wr_flush  out  1  drives the rst input of MEM/WR (bubble into WR).
- mem_err  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.
- flush_count  out  CNT_W  count of branch flushes.

Function
REQ-005 The block SHALL implement the FSM states RUN, MEM_WAIT and ERR; all outputs SHALL be combinational from the state and the inputs (Mealy).
REQ-006 The pipeline registers capture on the falling edge, so the outputs SHALL settle within the first half cycle after each rising edge.
REQ-007 In RUN with no event, the block SHALL drive all enables to 1 and all flushes to 0.
REQ-008 A load-use hazard SHALL be detected as ex_MemtoReg & ex_RegWr & ex_rw!=0 & (ex_rw==id_rs | (id_uses_rt & ex_rw==id_rt)).
REQ-009 On a load-use hazard in RUN, the block SHALL drive pc_en=0, if_id_en=0 and id_ex_flush=1 for one cycle with no state change; the condition clears naturally once the bubble has entered EX.
REQ-010 On branch_taken in RUN, the block SHALL drive if_id_flush=1 and id_ex_flush=1 while keeping pc_en=1, and SHALL increment flush_count.
REQ-011 Event priority in RUN SHALL be memory stall > branch flush > load-use; a load-use hazard coinciding with branch_taken SHALL be ignored because the dependent instruction is flushed.
REQ-012 The condition mem_req & !mem_ready in RUN SHALL select MEM_WAIT at the next edge, and in the same cycle the block SHALL drive pc_en, if_id_en, id_ex_en and ex_mem_en to 0 and mem_wr_flush to 1, with no flushes on IF/ID or ID/EX.
REQ-013 In MEM_WAIT, the block SHALL keep the freeze outputs of REQ-012, ignore branch_taken and load-use (both are re-evaluated after resume), and increment the wait counter every cycle.
REQ-014 In MEM_WAIT, mem_ready=1 SHALL release the freeze in that same cycle (all enables 1, mem_wr_flush 0), return the FSM to RUN and clear the wait counter.
REQ-015 In MEM_WAIT, if the wait counter equals WAIT_MAX-1 while mem_ready=0, the FSM SHALL enter ERR.
REQ-016 In ERR, all enables SHALL be 0, mem_wr_flush SHALL be 1, mem_err SHALL be 1, and the FSM SHALL leave ERR only on rst.
REQ-017 stall_cycles SHALL increment on every clock edge where pc_en=0 and rst=0, including ERR, and SHALL saturate at all-ones.
REQ-018 flush_count SHALL saturate at all-ones.

Reset
REQ-019 While rst=1, outputs SHALL be pc_en=if_id_en=id_ex_en=ex_mem_en=0 and if_id_flush=id_ex_flush=mem_wr_flush=1.
REQ-020 At a rising edge with rst=1, the state SHALL become RUN, and the wait counter, mem_err, stall_cycles and flush_count SHALL become 0.
REQ-021 Reset asserted mid-MEM_WAIT or in ERR SHALL take priority over all other inputs.
REQ-022 In the first cycle after rst deasserts, all enables SHALL be 1.

Verification
REQ-023 The bench SHALL cover load-use: ex_MemtoReg=1, ex_RegWr=1, ex_rw=5, id_rs=5 -> one cycle of pc_en=0 and id_ex_flush=1, stall_cycles=1; with ex_rw=0 -> no stall.
REQ-024 The bench SHALL cover branch plus load-use: branch_taken=1 with a load-use hazard present -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles=0.
REQ-025 The bench SHALL cover a memory wait: mem_req=1 with mem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wr_flush=1, resume on the 4th cycle, stall_cycles=3, mem_err=0.
REQ-026 The bench SHALL cover timeout: mem_req=1 and mem_ready=0 held with WAIT_MAX=8 -> ERR entered and mem_err=1, enables remain 0 afterwards even when mem_ready rises, and rst clears everything.
REQ-027 The bench SHALL cover a branch during MEM_WAIT: branch_taken=1 while frozen -> no flush and flush_count unchanged; after resume, a still-asserted branch_taken flushes once.
REQ-028 The bench SHALL cover saturation: with CNT_W=4, 20 forced stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master drives the hazard inputs; the slave (controller) drives the enables, flushes and counters.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_MemtoReg;
  logic             ex_RegWr;
  logic [4:0]       ex_rw;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wr_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_rw,
           branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wr_flush, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_rw,
           branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wr_flush, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait/timeout freeze.
// Outputs are Mealy so they settle before the falling-edge capture of the pipeline registers.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_load_use;
  logic w_mem_stall;
  logic w_freeze;
  logic w_flush_hit;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_en;
  logic w_id_ex_flush;
  logic w_ex_mem_en;
  logic w_mem_wr_flush;

  assign w_load_use = bus.ex_MemtoReg & bus.ex_RegWr & (bus.ex_rw != 5'd0) &
                      ((bus.ex_rw == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rw == bus.id_rt)));
  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    w_state_next   = r_state;
    w_freeze       = 1'b0;
    w_flush_hit    = 1'b0;
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_en    = 1'b1;
    w_mem_wr_flush = 1'b0;
    if (rst) begin
      w_state_next  = RUN;
      w_freeze      = 1'b1;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            w_state_next = MEM_WAIT;
            w_freeze     = 1'b1;
          end else if (bus.branch_taken) begin
            // A coincident load-use is moot: the dependent instruction is being flushed.
            w_flush_hit   = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            w_state_next = RUN;
          end else begin
            w_freeze = 1'b1;
            if (r_wait_cnt == WAIT_LAST) w_state_next = ERR;
          end
        end
        ERR:     w_freeze = 1'b1;
        default: w_state_next = RUN;
      endcase
    end
    if (w_freeze) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wr_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_next;
      // Counts cycles spent in MEM_WAIT; zero on entry and after leaving.
      if (r_state == MEM_WAIT && w_state_next == MEM_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                                                r_wait_cnt <= 8'd0;
      if (w_state_next == ERR) r_mem_err <= 1'b1;
      if (!w_pc_en && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_hit && r_flush_count != '1) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.mem_wr_flush = w_mem_wr_flush;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: constant vector table, hand-written multi-cycle sequences and random stimulus
// against a reference model that tracks the length of the current memory freeze as a plain integer.
module tb_pipe_hazard_ctrl;
  localparam int WM = 8;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       m2r;
    logic       regwr;
    logic [4:0] rw;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  // Output vector order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en mem_wr_flush mem_err
  localparam logic [7:0] O_RUN    = 8'b1101_0100;
  localparam logic [7:0] O_BR     = 8'b1111_1100;
  localparam logic [7:0] O_LU     = 8'b0001_1100;
  localparam logic [7:0] O_FRZ    = 8'b0000_0010;
  localparam logic [7:0] O_ERR    = 8'b0000_0011;
  localparam logic [7:0] O_RST    = 8'b0010_1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if_main ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  if_sat ();

  pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(16)) dut_main (.clk(clk), .rst(rst), .bus(if_main));
  pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(4))  dut_sat  (.clk(clk), .rst(rst), .bus(if_sat));

  int  n_checks = 0;
  int  n_fail   = 0;
  int  m_len    = 0;   // consecutive memory-frozen cycles so far; > WM means timed out
  int  m_stall  = 0;
  int  m_flush  = 0;
  in_t cur;
  vec_t vecs[10];

  function automatic in_t mk(input int rs, input int rt, input bit ut, input bit m2r, input bit rw_en,
                             input int rw, input bit br, input bit mreq, input bit mrdy);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = ut; v.m2r = m2r; v.regwr = rw_en;
    v.rw = 5'(rw); v.br = br; v.mreq = mreq; v.mrdy = mrdy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    cur = v;
    if_main.id_rs = v.rs; if_main.id_rt = v.rt; if_main.id_uses_rt = v.uses_rt;
    if_main.ex_MemtoReg = v.m2r; if_main.ex_RegWr = v.regwr; if_main.ex_rw = v.rw;
    if_main.branch_taken = v.br; if_main.mem_req = v.mreq; if_main.mem_ready = v.mrdy;
    if_sat.id_rs = v.rs; if_sat.id_rt = v.rt; if_sat.id_uses_rt = v.uses_rt;
    if_sat.ex_MemtoReg = v.m2r; if_sat.ex_RegWr = v.regwr; if_sat.ex_rw = v.rw;
    if_sat.branch_taken = v.br; if_sat.mem_req = v.mreq; if_sat.mem_ready = v.mrdy;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs_main();
    return {if_main.pc_en, if_main.if_id_en, if_main.if_id_flush, if_main.id_ex_en,
            if_main.id_ex_flush, if_main.ex_mem_en, if_main.mem_wr_flush, if_main.mem_err};
  endfunction

  function automatic logic [7:0] outs_sat();
    return {if_sat.pc_en, if_sat.if_id_en, if_sat.if_id_flush, if_sat.id_ex_en,
            if_sat.id_ex_flush, if_sat.ex_mem_en, if_sat.mem_wr_flush, if_sat.mem_err};
  endfunction

  function automatic int cap(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  // Reference behaviour for one cycle, from the hazard rules and the freeze length.
  task automatic model_eval(input in_t v, input logic r, output logic [7:0] o, output bit br_hit,
                            output bit frozen);
    bit err, hazard;
    err    = (m_len > WM);
    hazard = v.m2r && v.regwr && v.rw != 0 && (v.rw == v.rs || (v.uses_rt && v.rw == v.rt));
    frozen = err || (!v.mrdy && (m_len > 0 || v.mreq));
    br_hit = 1'b0;
    if (r)               o = O_RST | {7'b0, err};
    else if (frozen)     o = err ? O_ERR : O_FRZ;
    else if (m_len > 0)  o = O_RUN;
    else if (v.br)       begin o = O_BR; br_hit = 1'b1; end
    else if (hazard)     o = O_LU;
    else                 o = O_RUN;
  endtask

  task automatic cycle(input string tag, input bit use_exp, input logic [7:0] exp);
    logic [7:0] mo;
    bit br_hit, frozen;
    @(negedge clk);
    model_eval(cur, rst, mo, br_hit, frozen);
    $display("cyc %-12s rst=%0b in=%h out=%b model=%b stall=%0d flush=%0d", tag, rst, cur,
             outs_main(), mo, if_main.stall_cycles, if_main.flush_count);
    chk({tag, ":outs"}, outs_main(), mo);
    chk({tag, ":sat_outs"}, outs_sat(), mo);
    if (use_exp) chk({tag, ":vec"}, outs_main(), exp);
    chk({tag, ":stall"}, if_main.stall_cycles, cap(m_stall, 65535));
    chk({tag, ":flush"}, if_main.flush_count, cap(m_flush, 65535));
    chk({tag, ":sat_stall"}, if_sat.stall_cycles, cap(m_stall, 15));
    chk({tag, ":sat_flush"}, if_sat.flush_count, cap(m_flush, 15));
    if (rst) begin
      m_len = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!mo[7]) m_stall++;
      if (br_hit) m_flush++;
      if (m_len <= WM) m_len = frozen ? m_len + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle("rst0", 1'b0, 8'h00);
    cycle("rst1", 1'b1, O_RST);
    rst = 1'b0;
    cycle("rst_rel", 1'b1, O_RUN);
  endtask

  initial begin
    vecs[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_RUN};
    vecs[1] = '{mk(5, 0, 0, 1, 1, 5, 0, 0, 1), O_LU};
    vecs[2] = '{mk(5, 0, 0, 1, 1, 0, 0, 0, 1), O_RUN};
    vecs[3] = '{mk(1, 7, 1, 1, 1, 7, 0, 0, 1), O_LU};
    vecs[4] = '{mk(1, 7, 0, 1, 1, 7, 0, 0, 1), O_RUN};
    vecs[5] = '{mk(9, 0, 0, 0, 1, 9, 0, 0, 1), O_RUN};
    vecs[6] = '{mk(9, 0, 0, 1, 0, 9, 0, 0, 1), O_RUN};
    vecs[7] = '{mk(3, 4, 1, 0, 0, 0, 1, 0, 0), O_BR};
    vecs[8] = '{mk(6, 6, 1, 1, 1, 6, 1, 0, 1), O_BR};
    vecs[9] = '{mk(2, 2, 1, 1, 1, 2, 0, 1, 1), O_LU};

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;

    reset_dut();
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].in);
      cycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // load-use stalls once; ex_rw=0 never stalls
    reset_dut();
    apply(mk(5, 0, 0, 1, 1, 5, 0, 0, 1));
    cycle("lu_hit", 1'b1, O_LU);
    apply(mk(5, 0, 0, 1, 1, 0, 0, 0, 1));
    cycle("lu_rw0", 1'b1, O_RUN);
    chk("lu_stall_cnt", if_main.stall_cycles, 64'd1);

    // branch overrides a coincident load-use
    reset_dut();
    apply(mk(5, 0, 0, 1, 1, 5, 1, 0, 1));
    cycle("br_lu", 1'b1, O_BR);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle("br_after", 1'b1, O_RUN);
    chk("br_flush_cnt", if_main.flush_count, 64'd1);
    chk("br_stall_cnt", if_main.stall_cycles, 64'd0);

    // memory wait of three frozen cycles, resume on the fourth
    reset_dut();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cycle($sformatf("mw_frz%0d", i), 1'b1, O_FRZ);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    cycle("mw_resume", 1'b1, O_RUN);
    chk("mw_stall_cnt", if_main.stall_cycles, 64'd3);
    chk("mw_err", if_main.mem_err, 64'd0);

    // timeout: one RUN cycle plus WM wait cycles, then ERR is sticky
    reset_dut();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < WM + 1; i++) cycle($sformatf("to_frz%0d", i), 1'b1, O_FRZ);
    cycle("to_err", 1'b1, O_ERR);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
    cycle("to_err_rdy", 1'b1, O_ERR);
    chk("to_err_stall", if_main.stall_cycles, 64'(WM + 3));
    rst = 1'b1;
    cycle("to_rst", 1'b0, 8'h00);
    chk("to_rst_err", if_main.mem_err, 64'd0);
    chk("to_rst_stall", if_main.stall_cycles, 64'd0);
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle("to_after", 1'b1, O_RUN);

    // branch while frozen is ignored, then flushes once after resume
    reset_dut();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    cycle("bw_frz0", 1'b1, O_FRZ);
    cycle("bw_frz1", 1'b1, O_FRZ);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
    cycle("bw_resume", 1'b1, O_RUN);
    chk("bw_no_flush", if_main.flush_count, 64'd0);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    cycle("bw_flush", 1'b1, O_BR);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle("bw_idle", 1'b1, O_RUN);
    chk("bw_flush_cnt", if_main.flush_count, 64'd1);

    // saturation of the 4-bit counters
    reset_dut();
    apply(mk(5, 0, 0, 1, 1, 5, 0, 0, 1));
    for (int i = 0; i < 20; i++) cycle($sformatf("sat_lu%0d", i), 1'b1, O_LU);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 20; i++) cycle($sformatf("sat_br%0d", i), 1'b1, O_BR);
    chk("sat_stall15", if_sat.stall_cycles, 64'd15);
    chk("sat_flush15", if_sat.flush_count, 64'd15);
    chk("sat_main_stall", if_main.stall_cycles, 64'd20);

    // random traffic against the model
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      in_t v;
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) < 6));
      rst = ($urandom_range(0, 39) == 0);
      apply(v);
      cycle($sformatf("rnd%0d", i), 1'b0, 8'h00);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
